dvi_in_timing_tracker: RTL and testbench

- Pixel-clock stage directly upstream of the DVI-input framebuffer writer.
- Takes the decoded TMDS channel outputs (8-bit colour, DE, HSYNC, VSYNC) and turns them into the pixel/row/frame event stream the framebuffer writer consumes: is_video_data, row_complete, frame_complete, cx, cy.
- Measures active width and height.
- Tracks lock and stability of the incoming timing.
- Drops to a search state on channel-lock loss or sync timeout.

---
 rtl/dvi_in_timing_tracker.sv | 187 ++++++++++++++++++
 tb/tb_dvi_in_timing_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_in_timing_tracker.sv
// Pixel-clock timing tracker for the DVI input path: registers the decoded stream and
// derives pixel/row/frame events, active width/height, lock, stability and sync timeout.
module dvi_in_timing_tracker #(
    parameter logic VSYNC_POL      = 1'b1,
    parameter int   TIMEOUT_CYCLES = 2000000,
    parameter int   CNT_W          = 12
) (
    input  logic             pclk1x,
    input  logic             rst_ps,
    input  logic             channels_locked,
    input  logic             de_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [7:0]       red_i,
    input  logic [7:0]       green_i,
    input  logic [7:0]       blue_i,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             is_video_data,
    output logic             row_complete,
    output logic             frame_complete,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output logic             hsync_o,
    output logic             locked_o,
    output logic             stable_o,
    output logic             signal_lost_o
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        SEARCH       = 1'b0,
        ACTIVE_FRAME = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       red_q, red_d;
    logic [7:0]       green_q, green_d;
    logic [7:0]       blue_q, blue_d;
    logic             de_d_q, de_d_d;
    logic             vsync_d_q, vsync_d_d;
    logic             hsync_q, hsync_d;
    logic             row_complete_q, row_complete_d;
    logic             frame_complete_q, frame_complete_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cx_q, cx_d;
    logic [CNT_W-1:0] cy_q, cy_d;
    logic [CNT_W-1:0] cx_prev_q, cx_prev_d;
    logic [CNT_W-1:0] cy_prev_q, cy_prev_d;
    logic             stable_q, stable_d;
    logic             lost_q, lost_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic active;
    logic de_fall;
    logic vs_lead;
    logic timeout_hit;
    logic cy_inc;

    assign active      = (state_q == ACTIVE_FRAME);
    assign de_fall     = de_d_q & ~de_i;
    assign vs_lead     = (vsync_d_q != VSYNC_POL) && (vsync_i == VSYNC_POL);
    assign timeout_hit = active && !vs_lead && (to_q >= TO_LAST);

    always_comb begin
        state_d          = state_q;
        red_d            = red_i;
        green_d          = green_i;
        blue_d           = blue_i;
        de_d_d           = de_i;
        vsync_d_d        = vsync_i;
        hsync_d          = hsync_i;
        row_complete_d   = de_fall & active;
        frame_complete_d = vs_lead & active;
        pcnt_d           = pcnt_q;
        cx_d             = cx_q;
        cy_d             = cy_q;
        cx_prev_d        = cx_prev_q;
        cy_prev_d        = cy_prev_q;
        stable_d         = stable_q;
        lost_d           = lost_q;
        to_d             = to_q;
        cy_inc           = 1'b0;

        case (state_q)
            SEARCH:       if (vs_lead && channels_locked) state_d = ACTIVE_FRAME;
            ACTIVE_FRAME: if (timeout_hit) state_d = SEARCH;
            default:      state_d = SEARCH;
        endcase
        if (!channels_locked) state_d = SEARCH;

        if (de_fall) begin
            cx_d   = pcnt_q;
            pcnt_d = '0;
        end else if (de_i && pcnt_q != CNT_MAX) begin
            pcnt_d = pcnt_q + 1'b1;
        end

        // A final line ending on the frame boundary is counted now, so the snapshot includes it.
        cy_inc = row_complete_q | (vs_lead & de_fall & active);
        if (frame_complete_q) begin
            cy_d = '0;
        end else if (cy_inc && cy_q != CNT_MAX) begin
            cy_d = cy_q + 1'b1;
        end

        if (frame_complete_q) begin
            stable_d  = (cx_q == cx_prev_q) && (cy_q == cy_prev_q);
            cx_prev_d = cx_q;
            cy_prev_d = cy_q;
            lost_d    = 1'b0;
        end
        if (!channels_locked) stable_d = 1'b0;
        if (timeout_hit) lost_d = 1'b1;

        if (vs_lead) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
        end

        if (active && state_d == SEARCH) begin
            pcnt_d = '0;
            cx_d   = '0;
            cy_d   = '0;
        end
    end

    always_ff @(posedge pclk1x or posedge rst_ps) begin
        if (rst_ps) begin
            state_q          <= SEARCH;
            red_q            <= '0;
            green_q          <= '0;
            blue_q           <= '0;
            de_d_q           <= 1'b0;
            vsync_d_q        <= 1'b0;
            hsync_q          <= 1'b0;
            row_complete_q   <= 1'b0;
            frame_complete_q <= 1'b0;
            pcnt_q           <= '0;
            cx_q             <= '0;
            cy_q             <= '0;
            cx_prev_q        <= '0;
            cy_prev_q        <= '0;
            stable_q         <= 1'b0;
            lost_q           <= 1'b0;
            to_q             <= '0;
        end else begin
            state_q          <= state_d;
            red_q            <= red_d;
            green_q          <= green_d;
            blue_q           <= blue_d;
            de_d_q           <= de_d_d;
            vsync_d_q        <= vsync_d_d;
            hsync_q          <= hsync_d;
            row_complete_q   <= row_complete_d;
            frame_complete_q <= frame_complete_d;
            pcnt_q           <= pcnt_d;
            cx_q             <= cx_d;
            cy_q             <= cy_d;
            cx_prev_q        <= cx_prev_d;
            cy_prev_q        <= cy_prev_d;
            stable_q         <= stable_d;
            lost_q           <= lost_d;
            to_q             <= to_d;
        end
    end

    assign red            = red_q;
    assign green          = green_q;
    assign blue           = blue_q;
    assign is_video_data  = de_d_q & active;
    assign row_complete   = row_complete_q;
    assign frame_complete = frame_complete_q;
    assign cx             = cx_q;
    assign cy             = cy_q;
    assign hsync_o        = hsync_q;
    assign locked_o       = active;
    assign stable_o       = stable_q;
    assign signal_lost_o  = lost_q;

endmodule

// File: tb/tb_dvi_in_timing_tracker.sv
// Bench for dvi_in_timing_tracker: scaled-down frames with random pixels, checked against
// a frame-level model of the expected pulses, dimensions, lock, stability and timeout.
module tb_dvi_in_timing_tracker;

    localparam int CNT_W = 12;
    localparam int TO    = 1000;

    logic             pclk1x = 1'b0;
    logic             rst_ps;
    logic             channels_locked;
    logic             de_i, hsync_i, vsync_i;
    logic [7:0]       red_i, green_i, blue_i;
    logic [7:0]       red, green, blue;
    logic             is_video_data, row_complete, frame_complete;
    logic [CNT_W-1:0] cx, cy;
    logic             hsync_o, locked_o, stable_o, signal_lost_o;

    always #5 pclk1x = ~pclk1x;

    dvi_in_timing_tracker #(
        .VSYNC_POL      (1'b1),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .pclk1x          (pclk1x),
        .rst_ps          (rst_ps),
        .channels_locked (channels_locked),
        .de_i            (de_i),
        .hsync_i         (hsync_i),
        .vsync_i         (vsync_i),
        .red_i           (red_i),
        .green_i         (green_i),
        .blue_i          (blue_i),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .is_video_data   (is_video_data),
        .row_complete    (row_complete),
        .frame_complete  (frame_complete),
        .cx              (cx),
        .cy              (cy),
        .hsync_o         (hsync_o),
        .locked_o        (locked_o),
        .stable_o        (stable_o),
        .signal_lost_o   (signal_lost_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vs_cyc = 0;

    // per-window tallies gathered while driving
    int fc_cnt, rc_cnt, vid_cnt, overlap, run, line_w_exp;
    logic [CNT_W-1:0] fc_cx, fc_cy;
    logic fc_rc;

    // frame-level model
    bit m_locked = 0;
    bit m_lost   = 0;
    bit carry    = 0;
    int prev_w = 0, prev_h = 0;
    int rep_w  = 0, rep_h  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic de, input logic vs, input logic hs, input logic lk);
        logic [7:0] r, g, b;
        r = 8'($urandom_range(0, 255));
        g = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        de_i = de; vsync_i = vs; hsync_i = hs; channels_locked = lk;
        red_i = r; green_i = g; blue_i = b;
        @(posedge pclk1x);
        #1;
        cyc++;
        check_eq("colour", {8'h00, red, green, blue}, rst_ps ? 32'd0 : {8'h00, r, g, b});
        check_eq("hsync_o", {31'd0, hsync_o}, rst_ps ? 32'd0 : {31'd0, hs});
        if (is_video_data) begin
            vid_cnt++;
            run++;
        end
        if (row_complete) begin
            rc_cnt++;
            if (is_video_data) overlap++;
            check_eq("line_width", run, line_w_exp);
        end
        if (!is_video_data) run = 0;
        if (frame_complete) begin
            fc_cnt++;
            fc_cx = cx;
            fc_cy = cy;
            fc_rc = row_complete;
        end
    endtask

    // ev: 0 none, 1 channel-lock drop for 10 cycles, 2 async reset; at line ev_line pixel ev_px
    task automatic send_frame(input int w, input int h, input int gap, input bit tight,
                              input int ev, input int ev_line, input int ev_px);
        bit exp_fc;
        int exp_rc, exp_vid;
        logic lk;
        fc_cnt = 0; rc_cnt = 0; vid_cnt = 0; overlap = 0; fc_rc = 1'b0;
        exp_fc = m_locked;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 0) vs_cyc = cyc;
        end
        check_eq("fc_count", fc_cnt, {31'd0, exp_fc});
        if (exp_fc) begin
            check_eq("fc_cx", {20'd0, fc_cx}, prev_w);
            check_eq("fc_cy", {20'd0, fc_cy}, prev_h);
            check_eq("stable", {31'd0, stable_o}, {31'd0, (prev_w == rep_w && prev_h == rep_h)});
            rep_w  = prev_w;
            rep_h  = prev_h;
            m_lost = 0;
        end
        if (carry && exp_fc) check_eq("fc_with_rc", {31'd0, fc_rc}, 32'd1);
        check_eq("signal_lost", {31'd0, signal_lost_o}, {31'd0, m_lost});
        check_eq("locked_after_vs", {31'd0, locked_o}, 32'd1);
        m_locked = 1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int l = 0; l < h; l++) begin
            line_w_exp = w;
            for (int p = 0; p < w; p++) begin
                lk = !(ev == 1 && l == ev_line && p >= ev_px && p < ev_px + 10);
                if (ev == 2 && l == ev_line && p == ev_px) begin
                    rst_ps = 1'b1;
                    #1;
                    check_eq("rst_locked", {31'd0, locked_o}, 32'd0);
                    check_eq("rst_video", {31'd0, is_video_data}, 32'd0);
                    check_eq("rst_cx", {20'd0, cx}, 32'd0);
                    check_eq("rst_stable", {31'd0, stable_o}, 32'd0);
                    step(1'b1, 1'b0, 1'b0, 1'b1);
                    rst_ps = 1'b0;
                end else begin
                    step(1'b1, 1'b0, 1'b0, lk);
                end
                if (ev == 1 && l == ev_line && p == ev_px + 2) begin
                    check_eq("drop_locked", {31'd0, locked_o}, 32'd0);
                    check_eq("drop_stable", {31'd0, stable_o}, 32'd0);
                end
            end
            if (!(tight && l == h - 1))
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1, 1'b1);
        end
        if (!tight)
            for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        if (ev != 0) begin
            exp_rc  = int'(carry) + ev_line;
            exp_vid = ev_line * w + ev_px;
        end else begin
            exp_rc  = int'(carry) + (tight ? h - 1 : h);
            exp_vid = w * h;
        end
        check_eq("rc_count", rc_cnt, exp_rc);
        check_eq("vid_count", vid_cnt, exp_vid);
        check_eq("rc_overlap", overlap, 32'd0);
        prev_w = w;
        prev_h = h;
        carry  = tight;
        if (ev != 0) m_locked = 0;
        if (ev == 2) begin
            rep_w = 0; rep_h = 0; m_lost = 0;
        end
    endtask

    task automatic hold_for_timeout();
        fc_cnt = 0;
        while (cyc - vs_cyc < TO) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            if (cyc - vs_cyc == TO - 1) begin
                check_eq("pre_timeout_lost", {31'd0, signal_lost_o}, 32'd0);
                check_eq("pre_timeout_locked", {31'd0, locked_o}, 32'd1);
            end
        end
        check_eq("timeout_lost", {31'd0, signal_lost_o}, 32'd1);
        check_eq("timeout_locked", {31'd0, locked_o}, 32'd0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("timeout_no_fc", fc_cnt, 32'd0);
        m_lost   = 1;
        m_locked = 0;
    endtask

    initial begin
        run = 0; line_w_exp = 0;
        fc_cnt = 0; rc_cnt = 0; vid_cnt = 0; overlap = 0;
        fc_cx = '0; fc_cy = '0; fc_rc = 1'b0;
        rst_ps = 1'b1;
        channels_locked = 1'b0; de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
        red_i = '0; green_i = '0; blue_i = '0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("reset_video", {31'd0, is_video_data}, 32'd0);
        check_eq("reset_rc", {31'd0, row_complete}, 32'd0);
        check_eq("reset_fc", {31'd0, frame_complete}, 32'd0);
        check_eq("reset_cx", {20'd0, cx}, 32'd0);
        check_eq("reset_cy", {20'd0, cy}, 32'd0);
        check_eq("reset_locked", {31'd0, locked_o}, 32'd0);
        check_eq("reset_stable", {31'd0, stable_o}, 32'd0);
        check_eq("reset_lost", {31'd0, signal_lost_o}, 32'd0);
        rst_ps = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("idle_locked", {31'd0, locked_o}, 32'd0);

        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 1, 0, 0, 0, 0);
        send_frame(16, 16, 8, 0, 0, 0, 0);
        send_frame(16, 16, 8, 0, 0, 0, 0);
        send_frame(16, 16, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 1, 10, 5);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 1, 0, 0, 0);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        hold_for_timeout();
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 2, 5, 3);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 0, 0, 0);
        send_frame(20, 24, 8, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
